// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined ADD/SUB/ADC/SBC unit with a carry register for
// multi-word arithmetic and valid/ready handshakes on both sides.
// The output word is packed as {N, Z, C, V, result[WIDTH-1:0]}.
// Latency is STAGES cycles, and the unit sustains one beat per cycle while out_ready=1.
// Optional feature: define ADDSUB_SAT_EN to add the sat port. With sat=1, a result
// that overflows as a signed value clamps to the signed max or min.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+3:0] out
`ifdef ADDSUB_SAT_EN
  ,
  input  logic             sat
`endif
);

  localparam int OW = WIDTH + 4;

  if (WIDTH < 4 || STAGES < 1 || STAGES > 3) begin : g_bad_param
    $error("addsub_pipe: WIDTH must be >= 4 and STAGES must be 1..3");
  end

  logic              cf;
  logic [WIDTH-1:0]  b_eff;
  logic              cin;
  logic [WIDTH:0]    sum;
  logic              c_flag;
  logic              v_flag;
  logic [WIDTH-1:0]  res;
  logic [OW-1:0]     beat_word;
  logic              accept;

  logic [STAGES-1:0] slot_valid;
  logic [OW-1:0]     slot_data [STAGES];
  logic [STAGES-1:0] move;

  // Operand prep: op[0] selects subtract (invert b), op[1] selects carry-in from cf
  always_comb begin
    b_eff = op[0] ? ~in2 : in2;
    cin   = op[1] ? cf : op[0];
  end

  // Full-width sum with carry out, plus the carry and signed-overflow flags
  always_comb begin
    sum    = {1'b0, in1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    c_flag = sum[WIDTH];
    v_flag = (in1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
  end

  // Result selection; the clamp direction follows the sign of operand A
  always_comb begin
    res = sum[WIDTH-1:0];
`ifdef ADDSUB_SAT_EN
    if (sat && v_flag) begin
      res = in1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    beat_word = {res[WIDTH-1], (res == '0), c_flag, v_flag, res};
  end

  // Slot k may load when it is empty or its content moves on; chain runs from the output end
  always_comb begin
    logic chain;
    move  = '0;
    chain = !slot_valid[STAGES-1] || out_ready;
    move[STAGES-1] = chain;
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain   = !slot_valid[k] || chain;
      move[k] = chain;
    end
  end

  assign in_ready  = move[0];
  assign accept    = in_valid && in_ready;
  assign out_valid = slot_valid[STAGES-1];
  assign out       = slot_data[STAGES-1];

  // Carry register follows acceptance order, so chained ADC/SBC see the previous beat's C
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cf <= 1'b0;
    end else if (accept) begin
      cf <= c_flag;
    end
  end

  // Pipeline slots: each slot takes its predecessor's content whenever it is allowed to move
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      slot_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        slot_data[k] <= '0;
      end
    end else begin
      if (move[0]) begin
        slot_valid[0] <= accept;
        if (accept) begin
          slot_data[0] <= beat_word;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (move[k]) begin
          slot_valid[k] <= slot_valid[k-1];
          if (slot_valid[k-1]) begin
            slot_data[k] <= slot_data[k-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=32). The main instance uses STAGES=2.
// Two more instances (STAGES=1 and STAGES=3) share the same stimulus and are
// used for the latency check.
module tb_addsub_pipe;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          in_valid;
  logic [1:0]    op;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          out_ready;
`ifdef ADDSUB_SAT_EN
  logic          sat;
`endif

  logic          in_ready,  out_valid;
  logic [W+3:0]  out_w;
  logic          in_ready1, out_valid1;
  logic [W+3:0]  out1;
  logic          in_ready3, out_valid3;
  logic [W+3:0]  out3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .out(out_w)
`ifdef ADDSUB_SAT_EN
    , .sat(sat)
`endif
  );

  addsub_pipe #(.WIDTH(W), .STAGES(1)) dut_s1 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .in1(in1), .in2(in2), .out_valid(out_valid1),
    .out_ready(out_ready), .out(out1)
`ifdef ADDSUB_SAT_EN
    , .sat(sat)
`endif
  );

  addsub_pipe #(.WIDTH(W), .STAGES(3)) dut_s3 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready3),
    .op(op), .in1(in1), .in2(in2), .out_valid(out_valid3),
    .out_ready(out_ready), .out(out3)
`ifdef ADDSUB_SAT_EN
    , .sat(sat)
`endif
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [35:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic s, input logic [35:0] e);
    vec_t v;
    v.name = name; v.op = o; v.a = a; v.b = b; v.s = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One beat with out_ready=1: accept, wait for the output, and check latency and value.
  // Called at posedge+1 and returns at posedge+1 with the result still on out.
  task automatic run_vec(input vec_t v);
    int lat;
    op = v.op; in1 = v.a; in2 = v.b; in_valid = 1'b1;
`ifdef ADDSUB_SAT_EN
    sat = v.s;
`endif
    check({v.name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, "_latency"}, lat, 1);
    check({v.name, "_out"}, out_w, v.exp);
  endtask

  function automatic logic [35:0] stall_exp(input int i);
    logic [35:0] e;
    e = 36'(2 * i);
    if (i == 0) e = 36'h4_0000_0000;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat1, lat2, lat3;
    logic [35:0] o1, o2, o3;
    int sent, recv, occ;
    logic held_v;
    logic [35:0] held;
    logic acc, dlv;
    vec_t v;

    // Each entry: name, op, A, B, sat, expected {N,Z,C,V,result}
    add_vec("add_ovf",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 36'h9_8000_0000);
    add_vec("sub_zero",  2'b01, 32'h0000_0005, 32'h0000_0005, 1'b0, 36'h6_0000_0000);
    add_vec("sub_borrow",2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, 36'h8_FFFF_FFFF);
    add_vec("add_carry", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 36'h6_0000_0000);
    add_vec("adc_cf1",   2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0, 36'h0_0000_0001);
    add_vec("sbc_cf0",   2'b11, 32'h0000_0000, 32'h0000_0000, 1'b0, 36'h8_FFFF_FFFF);
    add_vec("add_negovf",2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 36'h7_0000_0000);
    add_vec("sbc_cf1",   2'b11, 32'h0000_0005, 32'h0000_0003, 1'b0, 36'h2_0000_0002);
    add_vec("sub_negovf",2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 36'h3_7FFF_FFFF);
    add_vec("adc_1p2",   2'b10, 32'h0000_0001, 32'h0000_0002, 1'b0, 36'h0_0000_0004);
    add_vec("add_plain", 2'b00, 32'h1234_5678, 32'h1111_1111, 1'b0, 36'h0_2345_6789);
`ifdef ADDSUB_SAT_EN
    add_vec("sat_pos",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 36'h1_7FFF_FFFF);
    add_vec("sat_neg",   2'b01, 32'h8000_0000, 32'h0000_0001, 1'b1, 36'hB_8000_0000);
    add_vec("sat_off",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 36'h9_8000_0000);
`endif

    clr_n = 1'b0; in_valid = 1'b0; op = 2'b00; in1 = '0; in2 = '0; out_ready = 1'b1;
`ifdef ADDSUB_SAT_EN
    sat = 1'b0;
`endif
    #17 clr_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_w, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid_s1", out_valid1, 0);
    check("rst_out_valid_s3", out_valid3, 0);

    // Latency across STAGES=1/2/3 with one overflowing ADD
    op = 2'b00; in1 = 32'h7FFF_FFFF; in2 = 32'h0000_0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat1 = -1; lat2 = -1; lat3 = -1; o1 = '0; o2 = '0; o3 = '0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid1 && lat1 < 0) begin lat1 = c; o1 = out1;  end
      if (out_valid  && lat2 < 0) begin lat2 = c; o2 = out_w; end
      if (out_valid3 && lat3 < 0) begin lat3 = c; o3 = out3;  end
      @(posedge clk); #1;
    end
    check("lat_s1", lat1, 0);
    check("lat_s2", lat2, 1);
    check("lat_s3", lat3, 2);
    check("lat_s1_out", o1, 36'h9_8000_0000);
    check("lat_s2_out", o2, 36'h9_8000_0000);
    check("lat_s3_out", o3, 36'h9_8000_0000);

    // Table of single beats; carry dependencies follow table order
    foreach (vecs[i]) begin
      v = vecs[i];
      run_vec(v);
    end
    @(posedge clk); #1;
    check("drain_out_valid", out_valid, 0);

    // 8 back-to-back ADDs i+i with the consumer stalled in cycles 3..6
    op = 2'b00;
    sent = 0; recv = 0; occ = 0; held_v = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 8);
      in1 = 32'(sent); in2 = 32'(sent);
      #1;
      check("stall_in_ready", in_ready, !(occ == 2 && !out_ready));
      if (held_v) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_out", out_w, held);
      end
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        check("stall_order", out_w, stall_exp(recv));
        recv++;
      end
      held_v = out_valid && !out_ready;
      held   = out_w;
      @(posedge clk); #1;
      occ = occ + int'(acc) - int'(dlv);
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_recv_count", recv, 8);
    check("stall_sent_count", sent, 8);
    @(posedge clk); #1;
    check("stall_no_dup", out_valid, 0);

    // Reset with two beats in flight clears the slots and the carry register
    v.name = "pre_rst_carry"; v.op = 2'b00; v.a = 32'hFFFF_FFFF; v.b = 32'h1; v.s = 1'b0;
    v.exp = 36'h6_0000_0000;
    run_vec(v);
    @(posedge clk); #1;
    out_ready = 1'b0;
    op = 2'b00; in1 = 32'h1; in2 = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in1 = 32'h2; in2 = 32'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_in_ready", in_ready, 0);
    #2 clr_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out", out_w, 0);
    #1 clr_n = 1'b1;
    #1;
    check("rst_rel_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_discard", out_valid, 0);
    v.name = "adc_after_rst"; v.op = 2'b10; v.a = 32'h0; v.b = 32'h0; v.s = 1'b0;
    v.exp = 36'h4_0000_0000;
    run_vec(v);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
